mdu_seq_ctrl: RTL and testbench



---
 rtl/mdu_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mdu_seq_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle M-extension multiply/divide sequencer sharing one radix-2 shift/add-subtract datapath.
// Define MDU_DIV_EN to build the restoring divider; without it div/rem ops return 0 at the same latency.
module mdu_seq_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_y,
    output logic             busy
);
    localparam int unsigned ACC_W = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] resp_y_q, resp_y_d;
    logic             resp_valid_q;
    logic             busy_q;
`ifdef MDU_DIV_EN
    logic             rneg_q, rneg_d;
    logic             bzero_q, bzero_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [ACC_W-1:0] div_next;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
`endif
    logic             accept;
    logic             a_sgn;
    logic             b_sgn;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [ACC_W-1:0] mul_next;
    logic [ACC_W-1:0] prod;
    logic [WIDTH-1:0] mul_res;

    assign req_ready = (state_q == S_IDLE) && !flush;
    assign accept    = req_valid && req_ready;

    // Operand signedness: DIV/REM both signed; MULH both; MULHSU rs1 only; MUL/MULHU/DIVU/REMU none
    assign a_sgn = req_a[WIDTH-1] & (req_op[2] ? ~req_op[0] : (req_op[1] ^ req_op[0]));
    assign b_sgn = req_b[WIDTH-1] & (req_op[2] ? ~req_op[0] : (req_op[1:0] == 2'b01));
    assign a_mag = a_sgn ? (WIDTH'(0) - req_a) : req_a;
    assign b_mag = b_sgn ? (WIDTH'(0) - req_b) : req_b;

    // Multiply step: acc = {partial, multiplier}; add multiplicand on LSB, shift right
    assign mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : WIDTH'(0))};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    assign prod    = neg_q ? (ACC_W'(0) - acc_q) : acc_q;
    assign mul_res = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[ACC_W-1:WIDTH];

`ifdef MDU_DIV_EN
    // Restoring divide step: acc = {remainder, dividend/quotient}; MIN_INT/-1 falls out of the magnitudes
    assign div_shift = acc_q[ACC_W-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
    assign quo_fix   = neg_q  ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    assign rem_fix   = rneg_q ? (WIDTH'(0) - acc_q[ACC_W-1:WIDTH]) : acc_q[ACC_W-1:WIDTH];
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        resp_y_d = resp_y_q;
`ifdef MDU_DIV_EN
        rneg_d   = rneg_q;
        bzero_d  = bzero_q;
        a_d      = a_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CALC;
                    op_d    = req_op;
                    neg_d   = a_sgn ^ b_sgn;
                    cnt_d   = '0;
                    if (req_op[2]) begin
                        acc_d  = {WIDTH'(0), a_mag};
                        opnd_d = b_mag;
                    end else begin
                        acc_d  = {WIDTH'(0), b_mag};
                        opnd_d = a_mag;
                    end
`ifdef MDU_DIV_EN
                    rneg_d  = a_sgn;
                    bzero_d = (req_b == '0);
                    a_d     = req_a;
`endif
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
`ifdef MDU_DIV_EN
                acc_d = op_q[2] ? div_next : mul_next;
`else
                acc_d = mul_next;
`endif
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
`ifdef MDU_DIV_EN
                if (!op_q[2]) begin
                    resp_y_d = mul_res;
                end else if (bzero_q) begin
                    resp_y_d = op_q[1] ? a_q : '1;
                end else begin
                    resp_y_d = op_q[1] ? rem_fix : quo_fix;
                end
`else
                resp_y_d = op_q[2] ? WIDTH'(0) : mul_res;
`endif
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            neg_q        <= 1'b0;
            opnd_q       <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            resp_y_q     <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef MDU_DIV_EN
            rneg_q       <= 1'b0;
            bzero_q      <= 1'b0;
            a_q          <= '0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            neg_q        <= neg_d;
            opnd_q       <= opnd_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            resp_y_q     <= resp_y_d;
            resp_valid_q <= (state_d == S_DONE);
            busy_q       <= (state_d != S_IDLE);
`ifdef MDU_DIV_EN
            rneg_q       <= rneg_d;
            bzero_q      <= bzero_d;
            a_q          <= a_d;
`endif
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_y     = resp_y_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Scoreboard bench for mdu_seq_ctrl: directed + random ops against an arithmetic reference model.
module tb_mdu_seq_ctrl;
    localparam int unsigned W   = 32;
    localparam int unsigned LAT = W + 2;
    localparam int ND = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic          flush;
    logic          resp_valid;
    logic          resp_ready;
    logic [W-1:0]  resp_y;
    logic          busy;

    mdu_seq_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        int           acc;
    } exp_t;

    exp_t scb[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [2:0]   d_op [ND] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7, 3'd6, 3'd4, 3'd6};
    logic [W-1:0] d_a  [ND] = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                                32'hFFFFFFF9, 32'hFFFFFFF9, 32'h1234, 32'h1234, 32'd9, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [W-1:0] d_b  [ND] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'd2, 32'd2, 32'd0, 32'd0, 32'd4, 32'd0, 32'd0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RISC-V M-extension semantics from 64-bit arithmetic
    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0]  ua, ub, sa, sbv, p;
        logic [W-1:0] res;
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        res = '0;
        case (op)
            3'd0: begin p = ua * ub;  res = p[31:0];  end
            3'd1: begin p = sa * sbv; res = p[63:32]; end
            3'd2: begin p = sa * ub;  res = p[63:32]; end
            3'd3: begin p = ua * ub;  res = p[63:32]; end
            3'd4: begin
                if (b == 0) res = '1;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = 32'h80000000;
                else res = $signed(a) / $signed(b);
            end
            3'd5: res = (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) res = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = '0;
                else res = $signed(a) % $signed(b);
            end
            default: res = (b == 0) ? a : a % b;
        endcase
`ifndef MDU_DIV_EN
        if (op[2]) res = '0;
`endif
        return res;
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h80000000;
            3:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: checks latency, value and hold stability; pops on handoff
    logic         prev_v = 1'b0;
    logic [W-1:0] held   = '0;
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (scb.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                if (!prev_v) begin
                    chk($sformatf("latency op%0d", scb[0].op), 64'(cyc - scb[0].acc), 64'(LAT));
                    chk($sformatf("resp_y op%0d a=%0h b=%0h", scb[0].op, scb[0].a, scb[0].b),
                        64'(resp_y), 64'(scb[0].y));
                    held = resp_y;
                end else begin
                    chk("hold_stable", 64'(resp_y), 64'(held));
                end
                if (resp_ready) void'(scb.pop_front());
            end
        end
        prev_v = rst_n && resp_valid && !resp_ready;
    end

    // Starts and ends at posedge+1
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        bit ok = 1'b0;
        exp_t e;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        e.op  = op;
        e.a   = a;
        e.b   = b;
        e.y   = model(op, a, b);
        e.acc = cyc;
        scb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_a     = W'($urandom);
        req_b     = W'($urandom);
    endtask

    task automatic wait_resp(input bit rnd);
        int n = 0;
        while (scb.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            resp_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            n++;
        end
        if (scb.size() != 0) begin
            chk("resp_timeout", 64'd0, 64'd1);
            scb.delete();
        end
        resp_ready = 1'b1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!resp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        flush = 1'b0; resp_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_y", 64'(resp_y), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < ND; i++) begin
            issue(d_op[i], d_a[i], d_b[i]);
            wait_resp(1'b0);
        end

        // Consumer stalls for 5 cycles in DONE
        resp_ready = 1'b0;
        issue(3'd0, W'($urandom), W'($urandom));
        chk("busy_after_accept", 64'(busy), 64'd1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            chk("hold_resp_valid", 64'(resp_valid), 64'd1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("handoff_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("post_handoff_req_ready", 64'(req_ready), 64'd1);
        chk("post_handoff_busy", 64'(busy), 64'd0);
        chk("post_handoff_resp_valid", 64'(resp_valid), 64'd0);
        @(posedge clk); #1;

        // Flush blocks accept in IDLE
        req_valid = 1'b1; req_op = 3'd0; req_a = 32'd3; req_b = 32'd5; flush = 1'b1;
        @(negedge clk);
        chk("flush_blocks_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_no_accept_busy", 64'(busy), 64'd0);

        // Flush at CALC cycle 10
        issue(3'd0, W'($urandom), W'($urandom));
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("busy_before_flush", 64'(busy), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        void'(scb.pop_back());
        chk("busy_after_flush", 64'(busy), 64'd0);
        chk("resp_valid_after_flush", 64'(resp_valid), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        issue(3'd0, 32'd3, 32'd5);
        wait_resp(1'b0);

        // Flush while holding a result in DONE
        resp_ready = 1'b0;
        issue(3'd1, rnd_opnd(), rnd_opnd());
        wait_valid();
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        void'(scb.pop_back());
        chk("done_flush_resp_valid", 64'(resp_valid), 64'd0);
        chk("done_flush_busy", 64'(busy), 64'd0);
        resp_ready = 1'b1;

        // Asynchronous reset at CALC cycle 20
        issue(3'd5, W'($urandom), W'($urandom_range(1, 255)));
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        scb.delete();
        #1;
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_resp_y", 64'(resp_y), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(3'd5, 32'd100, 32'd7);
        wait_resp(1'b0);

        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
            wait_resp(1'b1);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
